// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the instruction loader.
interface instr_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 32
);
    logic                  byte_valid;
    logic [7:0]            byte_data;
    logic                  byte_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/instr_loader.sv
// Boot loader: turns a length-prefixed byte stream into little-endian word writes
// and holds the CPU in reset until the whole program is in instruction memory.
module instr_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int WIDTH      = 32
) (
    input  logic          clk,
    input  logic          rst,
    instr_loader_if.slave bus,
    output logic          cpu_rst,
    output logic          done,
    output logic          err
);

    localparam int         IW  = ADDR_WIDTH - 2;
    localparam logic [16:0] CAP = 17'(2 ** IW);

    typedef enum logic [2:0] {
        CNT_LO,
        CNT_HI,
        DATA,
        DONE,
        ERR
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             armed;
    logic [7:0]       count_lo;
    logic [15:0]      count;
    logic [IW-1:0]    index;
    logic [1:0]       lane;
    logic [WIDTH-9:0] asm_q;
    logic             accept;
    logic [15:0]      n_word;
    logic             last_word;

    assign accept    = bus.byte_valid && bus.byte_ready;
    assign n_word    = {bus.byte_data, count_lo};
    assign last_word = (16'(index) + 16'd1) == count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= CNT_LO;
        end else begin
            state <= state_next;
        end
    end

    // armed keeps byte_ready low until the first edge after reset is released
    always_comb begin
        state_next     = state;
        bus.byte_ready = armed && (state inside {CNT_LO, CNT_HI, DATA});
        done           = (state == DONE);
        err            = (state == ERR);
        cpu_rst        = (state != DONE);
        case (state)
            CNT_LO: begin
                if (accept) state_next = CNT_HI;
            end
            CNT_HI: begin
                if (accept) begin
                    if (n_word == 16'd0)
                        state_next = DONE;
                    else if ({1'b0, n_word} > CAP)
                        state_next = ERR;
                    else
                        state_next = DATA;
                end
            end
            DATA: begin
                if (accept && lane == 2'd3 && last_word) state_next = DONE;
            end
            default: state_next = state;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed         <= 1'b0;
            count_lo      <= '0;
            count         <= '0;
            index         <= '0;
            lane          <= '0;
            asm_q         <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            armed      <= 1'b1;
            bus.mem_we <= 1'b0;
            if (accept) begin
                case (state)
                    CNT_LO: count_lo <= bus.byte_data;
                    CNT_HI: begin
                        count <= n_word;
                        index <= '0;
                        lane  <= '0;
                    end
                    DATA: begin
                        // newest byte enters at the top, so byte 0 ends in bits 7:0
                        asm_q <= {bus.byte_data, asm_q[WIDTH-9:8]};
                        lane  <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            bus.mem_we    <= 1'b1;
                            bus.mem_wdata <= {bus.byte_data, asm_q};
                            bus.mem_addr  <= {index, 2'b00};
                            index         <= index + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Scoreboard bench for instr_loader: directed byte streams in, monitored word writes out.
module tb_instr_loader;

    localparam int ADDR_WIDTH = 8;
    localparam int WIDTH      = 32;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } wr_t;

    logic clk;
    logic rst;
    logic cpu_rst;
    logic done;
    logic err;
    int   total;
    int   bad;
    int   writeCount;
    int   wcBase;
    wr_t  sb[$];
    logic [7:0] prog1[$];
    logic [7:0] progBig[$];
    logic [7:0] partial[$];

    instr_loader_if #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)) lif ();

    instr_loader #(.ADDR_WIDTH(ADDR_WIDTH), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (lif),
        .cpu_rst (cpu_rst),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Monitor: every write strobe is matched against the oldest expected write
    always @(negedge clk) begin
        wr_t exp;
        if (rst && lif.mem_we) begin
            writeCount++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_write: got addr %h data %h, expected no write",
                         lif.mem_addr, lif.mem_wdata);
            end else begin
                exp = sb.pop_front();
                checkOutput("wr_addr", 32'(lif.mem_addr), 32'(exp.addr));
                checkOutput("wr_data", lif.mem_wdata, exp.data);
            end
        end
    end

    task automatic expectWord(input logic [ADDR_WIDTH-1:0] addr, input logic [WIDTH-1:0] data);
        sb.push_back('{addr: addr, data: data});
    endtask

    task automatic sendByte(input logic [7:0] b, input int gap);
        int waited;
        for (int g = 0; g < gap; g++) @(negedge clk);
        lif.byte_valid = 1'b1;
        lif.byte_data  = b;
        waited = 0;
        while (!lif.byte_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) begin
            total++;
            bad++;
            $display("[TB] FAIL accept_timeout: got byte_ready 0 for %0d cycles, expected 1", waited);
        end else begin
            @(negedge clk);
        end
        lif.byte_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] bytes[$], input int gapMax);
        foreach (bytes[i]) sendByte(bytes[i], (gapMax > 0) ? int'($urandom_range(0, gapMax)) : 0);
    endtask

    task automatic resetDut();
        @(negedge clk);
        lif.byte_valid = 1'b0;
        rst = 1'b0;
        #2;
        checkOutput("rst_ready", 32'(lif.byte_ready), 32'd0);
        checkOutput("rst_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("rst_done_err", {30'd0, done, err}, 32'd0);
        checkOutput("rst_mem_we", 32'(lif.mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(lif.mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", lif.mem_wdata, 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(lif.byte_ready), 32'd1);
    endtask

    task automatic holdValid(input int cycles);
        lif.byte_valid = 1'b1;
        lif.byte_data  = 8'hEE;
        for (int c = 0; c < cycles; c++) @(negedge clk);
        lif.byte_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total          = 0;
        bad            = 0;
        writeCount     = 0;
        rst            = 1'b1;
        lif.byte_valid = 1'b0;
        lif.byte_data  = 8'h00;
        prog1 = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};

        // Two-word load, one byte per cycle
        resetDut();
        wcBase = writeCount;
        expectWord(8'h00, 32'h00A00513);
        expectWord(8'h04, 32'h00100593);
        applyStimulus(prog1, 0);
        checkOutput("last_we_with_done", {30'd0, lif.mem_we, done}, 32'd3);
        checkOutput("load_cpu_rst", 32'(cpu_rst), 32'd0);
        checkOutput("load_err", 32'(err), 32'd0);
        @(negedge clk);
        checkOutput("load_writes", 32'(writeCount - wcBase), 32'd2);
        checkOutput("load_sb_empty", 32'(sb.size()), 32'd0);

        // Extra bytes after DONE are ignored
        wcBase = writeCount;
        holdValid(6);
        checkOutput("post_done_ready", 32'(lif.byte_ready), 32'd0);
        checkOutput("post_done_writes", 32'(writeCount - wcBase), 32'd0);
        checkOutput("post_done_state", {30'd0, done, cpu_rst}, 32'd2);
        checkOutput("post_done_hold", lif.mem_wdata, 32'h00100593);

        // Zero-length program
        resetDut();
        wcBase = writeCount;
        partial = '{8'h00, 8'h00};
        applyStimulus(partial, 0);
        checkOutput("zero_done", 32'(done), 32'd1);
        checkOutput("zero_cpu_rst", 32'(cpu_rst), 32'd0);
        @(negedge clk);
        checkOutput("zero_writes", 32'(writeCount - wcBase), 32'd0);

        // Capacity exceeded: 65 words into 64-word memory
        resetDut();
        wcBase = writeCount;
        partial = '{8'h41, 8'h00};
        applyStimulus(partial, 0);
        checkOutput("err_flag", 32'(err), 32'd1);
        checkOutput("err_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("err_done", 32'(done), 32'd0);
        holdValid(8);
        checkOutput("err_ready", 32'(lif.byte_ready), 32'd0);
        checkOutput("err_writes", 32'(writeCount - wcBase), 32'd0);

        // Full-capacity load: word i holds bytes 4i..4i+3
        resetDut();
        wcBase = writeCount;
        progBig = '{8'h40, 8'h00};
        for (int i = 0; i < 64; i++) begin
            logic [7:0] b0;
            b0 = 8'(4 * i);
            expectWord(8'(4 * i), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
            for (int k = 0; k < 4; k++) progBig.push_back(b0 + 8'(k));
        end
        applyStimulus(progBig, 0);
        checkOutput("big_last_addr", 32'(lif.mem_addr), 32'h000000FC);
        checkOutput("big_last_data", lif.mem_wdata, 32'hFFFEFDFC);
        checkOutput("big_done", {30'd0, done, cpu_rst}, 32'd2);
        @(negedge clk);
        checkOutput("big_writes", 32'(writeCount - wcBase), 32'd64);
        checkOutput("big_sb_empty", 32'(sb.size()), 32'd0);

        // Same two-word program with random gaps on byte_valid
        resetDut();
        wcBase = writeCount;
        expectWord(8'h00, 32'h00A00513);
        expectWord(8'h04, 32'h00100593);
        applyStimulus(prog1, 5);
        checkOutput("gap_done", {30'd0, done, cpu_rst}, 32'd2);
        @(negedge clk);
        checkOutput("gap_writes", 32'(writeCount - wcBase), 32'd2);
        checkOutput("gap_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-load, then replay the full stream
        resetDut();
        expectWord(8'h00, 32'h00A00513);
        partial = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00};
        applyStimulus(partial, 0);
        checkOutput("mid_ready_before", 32'(lif.byte_ready), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_async_ready", 32'(lif.byte_ready), 32'd0);
        checkOutput("mid_async_cpu_rst", 32'(cpu_rst), 32'd1);
        checkOutput("mid_async_wdata", lif.mem_wdata, 32'd0);
        checkOutput("mid_sb_empty", 32'(sb.size()), 32'd0);
        resetDut();
        wcBase = writeCount;
        expectWord(8'h00, 32'h00A00513);
        expectWord(8'h04, 32'h00100593);
        applyStimulus(prog1, 0);
        checkOutput("replay_done", {30'd0, done, cpu_rst}, 32'd2);
        @(negedge clk);
        checkOutput("replay_writes", 32'(writeCount - wcBase), 32'd2);
        checkOutput("replay_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
